r22sdf_frame_ctrl: RTL and testbench

R22SDF_FRAME_CTRL -- requirements
Module: r22sdf_frame_ctrl

---
 rtl/r22sdf_frame_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_r22sdf_frame_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/r22sdf_frame_ctrl.sv
// r22sdf_frame_ctrl: frame, fill and flush sequencer for an R2^2 SDF FFT core.
// Define R22SDF_FRAME_CNT_EN to build the completed-output-frame counter.
module r22sdf_frame_ctrl #(
    parameter int FFT_LENGTH   = 16384,
    parameter int PIPE_LATENCY = 16400
) (
    input  logic        sys_clk,
    input  logic        sys_nrst,
    input  logic        cordic_rdy,
    input  logic        in_valid,
    input  logic        in_sop,
    output logic        in_ready,
    input  logic        flush,
    output logic        fft_en,
    output logic        out_valid,
    output logic        out_sop,
    output logic        out_eop,
    output logic        sop_err,
    output logic        busy,
    output logic [31:0] frame_cnt
);

    localparam int IDX_W = $clog2(FFT_LENGTH);
    localparam int CNT_W = $clog2(PIPE_LATENCY + 1);

    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(1'b0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FFT_LENGTH - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(PIPE_LATENCY);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [IDX_W-1:0]   in_idx_r;
    logic [IDX_W-1:0]   in_idx_nxt_s;
    logic [IDX_W-1:0]   out_idx_r;
    logic [CNT_W-1:0]   fill_r;
    logic [CNT_W-1:0]   pend_r;
    logic               flush_lat_r;
    logic               flush_lat_nxt_s;
    logic               sop_err_r;
    logic               err_s;
    logic               enter_s;
    logic               fill_clr_s;
    logic               boundary_s;

    // Next-state, input handshake and core enable decode
    always_comb begin
        state_nxt_s     = state_r;
        in_idx_nxt_s    = in_idx_r;
        flush_lat_nxt_s = flush_lat_r;
        in_ready        = 1'b0;
        fft_en          = 1'b0;
        enter_s         = 1'b0;
        err_s           = 1'b0;
        fill_clr_s      = 1'b0;
        // a pending flush stalls the source exactly at the frame boundary
        boundary_s      = (flush_lat_r | flush) & (in_idx_r == IDX_ZERO);
        case (state_r)
            ST_INIT: begin
                if (cordic_rdy) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_IDLE: begin
                in_ready = cordic_rdy;
                if (in_valid && cordic_rdy) begin
                    if (in_sop) begin
                        fft_en       = 1'b1;
                        enter_s      = 1'b1;
                        in_idx_nxt_s = IDX_ONE;
                        state_nxt_s  = ST_RUN;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    err_s = 1'b0;
                end
            end
            ST_RUN: begin
                in_ready = cordic_rdy & ~boundary_s;
                fft_en   = in_valid & cordic_rdy & ~boundary_s;
                enter_s  = fft_en;
                if (fft_en) begin
                    if (in_sop && (in_idx_r != IDX_ZERO)) begin
                        err_s        = 1'b1;
                        in_idx_nxt_s = IDX_ONE;
                    end else begin
                        in_idx_nxt_s = in_idx_r + IDX_ONE;
                    end
                end else begin
                    in_idx_nxt_s = in_idx_r;
                end
                if (cordic_rdy && boundary_s) begin
                    state_nxt_s     = ST_FLUSH;
                    flush_lat_nxt_s = 1'b0;
                end else if (flush) begin
                    flush_lat_nxt_s = 1'b1;
                end else begin
                    flush_lat_nxt_s = flush_lat_r;
                end
            end
            ST_FLUSH: begin
                fft_en = cordic_rdy;
                if (cordic_rdy && (pend_r == CNT_ZERO)) begin
                    state_nxt_s = ST_IDLE;
                    fill_clr_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            default: begin
                state_nxt_s = ST_INIT;
            end
        endcase
    end

    assign out_valid = fft_en & (fill_r == FILL_MAX) & (pend_r != CNT_ZERO);
    assign out_sop   = out_valid & (out_idx_r == IDX_ZERO);
    assign out_eop   = out_valid & (out_idx_r == IDX_LAST);
    assign sop_err   = sop_err_r;
    assign busy      = (state_r != ST_IDLE);

    // FSM state, input frame position, flush latch and error pulse
    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            state_r     <= ST_INIT;
            in_idx_r    <= IDX_ZERO;
            flush_lat_r <= 1'b0;
            sop_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_idx_r    <= in_idx_nxt_s;
            flush_lat_r <= flush_lat_nxt_s;
            sop_err_r   <= err_s;
        end
    end

    // Pipeline fill level and number of samples still inside the core
    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            fill_r <= CNT_ZERO;
            pend_r <= CNT_ZERO;
        end else begin
            if (fill_clr_s) begin
                fill_r <= CNT_ZERO;
            end else if (fft_en && (fill_r != FILL_MAX)) begin
                fill_r <= fill_r + CNT_ONE;
            end else begin
                fill_r <= fill_r;
            end
            case ({enter_s, out_valid})
                2'b10:   pend_r <= pend_r + CNT_ONE;
                2'b01:   pend_r <= pend_r - CNT_ONE;
                default: pend_r <= pend_r;
            endcase
        end
    end

    // Output frame position
    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            out_idx_r <= IDX_ZERO;
        end else if (out_valid) begin
            out_idx_r <= out_idx_r + IDX_ONE;
        end else begin
            out_idx_r <= out_idx_r;
        end
    end

`ifdef R22SDF_FRAME_CNT_EN
    logic [31:0] frame_cnt_r;

    // Completed output frames, wrapping at 2^32
    always_ff @(posedge sys_clk or negedge sys_nrst) begin
        if (!sys_nrst) begin
            frame_cnt_r <= 32'd0;
        end else if (out_eop) begin
            frame_cnt_r <= frame_cnt_r + 32'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign frame_cnt = frame_cnt_r;
`else
    assign frame_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_r22sdf_frame_ctrl.sv
// Scoreboard bench for r22sdf_frame_ctrl: a session-level reference model predicts
// per-cycle handshake/enable values and the ordered output beats.
module tb_r22sdf_frame_ctrl;

    localparam int N  = 16;
    localparam int PL = 20;

    logic        sys_clk    = 1'b0;
    logic        sys_nrst   = 1'b0;
    logic        cordic_rdy = 1'b0;
    logic        in_valid   = 1'b0;
    logic        in_sop     = 1'b0;
    logic        flush      = 1'b0;
    logic        in_ready;
    logic        fft_en;
    logic        out_valid;
    logic        out_sop;
    logic        out_eop;
    logic        sop_err;
    logic        busy;
    logic [31:0] frame_cnt;

    r22sdf_frame_ctrl #(.FFT_LENGTH(N), .PIPE_LATENCY(PL)) dut (
        .sys_clk    (sys_clk),
        .sys_nrst   (sys_nrst),
        .cordic_rdy (cordic_rdy),
        .in_valid   (in_valid),
        .in_sop     (in_sop),
        .in_ready   (in_ready),
        .flush      (flush),
        .fft_en     (fft_en),
        .out_valid  (out_valid),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .sop_err    (sop_err),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        ir, en, ov, osop, oeop, err, busy;
        logic [31:0] fcnt;
    } ctrl_t;
    typedef struct packed {
        logic sop, eop;
    } beat_t;

    ctrl_t ctrl_q[$];
    beat_t beat_q[$];
    ctrl_t mon_c;
    beat_t mon_b;

    // reference model: session-level bookkeeping
    bit m_started, m_run, m_drain, m_flush_req, m_err_prev;
    int m_pos, m_en_cnt, m_entered, m_out_sess, m_out_total, m_frames;

    int dut_out_cnt = 0;
    int dut_en_cnt  = 0;
    int first_ov_en = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_fcnt();
`ifdef R22SDF_FRAME_CNT_EN
        return 32'(m_frames);
`else
        return 32'd0;
`endif
    endfunction

    function automatic void model_reset();
        m_started = 0; m_run = 0; m_drain = 0; m_flush_req = 0; m_err_prev = 0;
        m_pos = 0; m_en_cnt = 0; m_entered = 0; m_out_sess = 0; m_out_total = 0; m_frames = 0;
    endfunction

    function automatic void model_cycle(input bit rdy, input bit v, input bit sop, input bit fl);
        ctrl_t c;
        beat_t b;
        bit enter, err, go_idle, bnd;
        int ord;
        c = '0;
        enter = 0; err = 0; go_idle = 0;
        c.err  = m_err_prev;
        c.fcnt = exp_fcnt();
        c.busy = !(m_started && !m_run && !m_drain);
        if (!rdy) begin
            if (m_run && fl) m_flush_req = 1;
        end else if (!m_started) begin
            m_started = 1;
        end else if (m_run) begin
            bnd  = (m_flush_req || fl) && (m_pos == 0);
            c.ir = !bnd;
            c.en = v && !bnd;
            enter = c.en;
            if (enter) begin
                if (sop && m_pos != 0) begin err = 1; m_pos = 1; end
                else m_pos = (m_pos + 1) % N;
            end
            if (bnd) begin m_run = 0; m_drain = 1; m_flush_req = 0; end
            else if (fl) m_flush_req = 1;
        end else if (m_drain) begin
            c.en = 1;
            if (m_entered == m_out_sess) go_idle = 1;
        end else begin
            c.ir = 1;
            if (v) begin
                if (sop) begin c.en = 1; enter = 1; m_run = 1; m_pos = 1; end
                else err = 1;
            end
        end
        // a result leaves PL enabled cycles after its sample entered
        c.ov = c.en && (m_en_cnt >= PL) && (m_entered - m_out_sess > 0);
        if (c.ov) begin
            ord    = m_out_total % N;
            c.osop = (ord == 0);
            c.oeop = (ord == N - 1);
            b.sop  = c.osop;
            b.eop  = c.oeop;
            beat_q.push_back(b);
            m_out_sess++;
            m_out_total++;
            if (c.oeop) m_frames++;
        end
        if (c.en) m_en_cnt++;
        if (enter) m_entered++;
        if (go_idle) begin m_drain = 0; m_en_cnt = 0; m_entered = 0; m_out_sess = 0; end
        m_err_prev = err;
        ctrl_q.push_back(c);
    endfunction

    // monitor: per-cycle control check and output-beat scoreboard
    always @(negedge sys_clk) begin
        if (ctrl_q.size() > 0) begin
            mon_c = ctrl_q.pop_front();
            chk("in_ready",  32'(in_ready),  32'(mon_c.ir));
            chk("fft_en",    32'(fft_en),    32'(mon_c.en));
            chk("out_valid", 32'(out_valid), 32'(mon_c.ov));
            chk("out_sop",   32'(out_sop),   32'(mon_c.osop));
            chk("out_eop",   32'(out_eop),   32'(mon_c.oeop));
            chk("sop_err",   32'(sop_err),   32'(mon_c.err));
            chk("busy",      32'(busy),      32'(mon_c.busy));
            chk("frame_cnt", frame_cnt,      mon_c.fcnt);
        end
        if (fft_en) dut_en_cnt++;
        if (out_valid) begin
            dut_out_cnt++;
            if (first_ov_en == 0) first_ov_en = dut_en_cnt;
            if (beat_q.size() == 0) begin
                chk("beat_unexpected", 32'd1, 32'd0);
            end else begin
                mon_b = beat_q.pop_front();
                chk("beat_sop", 32'(out_sop), 32'(mon_b.sop));
                chk("beat_eop", 32'(out_eop), 32'(mon_b.eop));
            end
        end
    end

    task automatic step(input bit rdy, input bit v, input bit sop, input bit fl);
        cordic_rdy = rdy; in_valid = v; in_sop = sop; flush = fl;
        model_cycle(rdy, v, sop, fl);
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send_beats(input int n, input int gap_pct);
        int sent = 0;
        for (int k = 0; k < n * 10 && sent < n; k++) begin
            bit v;
            v = ($urandom_range(99, 0) >= gap_pct);
            step(1'b1, v, v && (m_pos == 0), 1'b0);
            if (v) sent++;
        end
    endtask

    task automatic finish_drain();
        bit done = 0;
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 200 && !done; k++) begin
            if (m_run)        step(1'b1, 1'b1, 1'b0, 1'b0);
            else if (m_drain) step(1'b1, 1'b0, 1'b0, 1'b0);
            else              done = 1;
        end
        chk("drain_done", 32'(done), 32'd1);
    endtask

    task automatic reset_check();
        sys_nrst = 1'b0; cordic_rdy = 1'b0; in_valid = 1'b0; in_sop = 1'b0; flush = 1'b0;
        #1;
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_fft_en",    32'(fft_en),    32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sop",   32'(out_sop),   32'd0);
        chk("rst_out_eop",   32'(out_eop),   32'd0);
        chk("rst_sop_err",   32'(sop_err),   32'd0);
        chk("rst_busy",      32'(busy),      32'd1);
        chk("rst_frame_cnt", frame_cnt,      32'd0);
        model_reset();
        @(negedge sys_clk);
        sys_nrst = 1'b1;
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        bit rdy, v, sop, fl;
        logic [31:0] exp3;
        model_reset();
        @(posedge sys_clk);
        #1;
        reset_check();

        // INIT hold with cordic_rdy low, then release
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("idle_after_rdy", 32'(busy), 32'd0);

        // three back-to-back frames then flush
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < N; i++) step(1'b1, 1'b1, i == 0, 1'b0);
        finish_drain();
        chk("first_out_en_cycle", 32'(first_ov_en), 32'd21);
        chk("out_count_48", 32'(dut_out_cnt), 32'd48);
        chk("idle_after_flush", 32'(busy), 32'd0);
`ifdef R22SDF_FRAME_CNT_EN
        exp3 = 32'd3;
`else
        exp3 = 32'd0;
`endif
        chk("frame_cnt_3", frame_cnt, exp3);

        // framing errors: discard in IDLE, early sop inside a frame
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("idle_discard_err", 32'(sop_err), 32'd1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, i == 0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("early_sop_err", 32'(sop_err), 32'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("sop_err_one_cycle", 32'(sop_err), 32'd0);
        send_beats(30, 20);
        finish_drain();

        // cordic_rdy drop mid-frame while outputs are flowing
        send_beats(22, 0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        send_beats(26, 10);
        finish_drain();
        chk("no_loss", 32'(dut_out_cnt), 32'(m_out_total));

        // flush requested at index 5 takes effect after index 15
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, i == 0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 6; i < N; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("flush_state_busy", 32'(busy), 32'd1);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        reset_check();

        // new frame after a mid-flush reset
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_beats(16, 0);
        finish_drain();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rdy = ($urandom_range(9, 0) != 0);
            v   = ($urandom_range(3, 0) != 0);
            sop = (m_pos == 0) ? ($urandom_range(7, 0) != 0) : ($urandom_range(29, 0) == 0);
            fl  = rdy && m_run && ($urandom_range(39, 0) == 0);
            step(rdy, v, sop, fl);
        end
        finish_drain();

        chk("beat_q_empty", 32'(beat_q.size()), 32'd0);
        chk("final_frame_cnt", frame_cnt, exp_fcnt());
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
